// File: rtl/mpmc10_resv_mgr.sv
// mpmc10_resv_mgr: reservation table for load-reserved lines, round-robin set
// arbitration across channels and line invalidation on committed writes.
module mpmc10_resv_mgr #(
    parameter int NCH = 8,
    parameter int NAR = 4,
    parameter logic [3:0] IDLE = 4'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        state,
    input  logic [NCH-1:0]    resv_req,
    input  logic [32*NCH-1:0] resv_adr_i,
    output logic [NCH-1:0]    resv_ack,
    input  logic              wr,
    input  logic [3:0]        wch,
    input  logic [31:0]       wadr,
    output logic [4*NAR-1:0]  resv_ch,
    output logic [32*NAR-1:0] resv_adr,
    output logic [NAR-1:0]    resv_vld
);
    localparam int VW = $clog2(NAR);

    logic [3:0]     ch_q [NAR];
    logic [3:0]     ch_d [NAR];
    logic [31:0]    adr_q [NAR];
    logic [31:0]    adr_d [NAR];
    logic [NAR-1:0] vld_q, vld_d;
    logic [NCH-1:0] ack_q, ack_d, elig;
    logic [3:0]     rr_q, rr_d, gi;
    logic [VW-1:0]  vic_q, vic_d, osel, fsel, sel;
    logic           gnt, own, free, idle;
    int             gsel;

    // Write channel is not needed: a matching store clears the line whoever owns it.
    logic unused_ok;
    assign unused_ok = ^{wch, wadr[4:0]};

    assign idle = (state == IDLE);
    // A requester seeing its ack this cycle must not be granted again.
    assign elig = resv_req & ~ack_q;

    always_comb begin
        ch_d  = ch_q;
        adr_d = adr_q;
        vld_d = vld_q;
        ack_d = '0;
        rr_d  = rr_q;
        vic_d = vic_q;
        gnt   = 1'b0;
        gsel  = 0;
        own   = 1'b0;
        free  = 1'b0;
        osel  = '0;
        fsel  = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (elig[(int'(rr_q) + k) % NCH]) begin
                gnt  = 1'b1;
                gsel = (int'(rr_q) + k) % NCH;
            end
        end
        gi = 4'(gsel);
        for (int e = NAR - 1; e >= 0; e--) begin
            if (!vld_q[e]) begin
                free = 1'b1;
                fsel = VW'(e);
            end
            if (vld_q[e] && ch_q[e] == gi) begin
                own  = 1'b1;
                osel = VW'(e);
            end
        end
        sel = own ? osel : (free ? fsel : vic_q);
        if (idle) begin
            for (int e = 0; e < NAR; e++) begin
                if (wr && vld_q[e] && adr_q[e][31:5] == wadr[31:5]) begin
                    vld_d[e] = 1'b0;
                    ch_d[e]  = 4'hF;
                end
                if (gnt && vld_q[e] && ch_q[e] == gi && VW'(e) != sel) begin
                    vld_d[e] = 1'b0;
                    ch_d[e]  = 4'hF;
                end
            end
            if (gnt) begin
                ch_d[sel]  = gi;
                adr_d[sel] = resv_adr_i[32*gsel +: 32];
                vld_d[sel] = 1'b1;
                ack_d      = NCH'(1) << gsel;
                rr_d       = (gi == 4'(NCH - 1)) ? 4'd0 : gi + 4'd1;
                vic_d      = (own || free) ? vic_q : vic_q + VW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NAR; e++) begin
                ch_q[e]  <= 4'hF;
                adr_q[e] <= '0;
            end
            vld_q <= '0;
            ack_q <= '0;
            rr_q  <= '0;
            vic_q <= '0;
        end else begin
            ch_q  <= ch_d;
            adr_q <= adr_d;
            vld_q <= vld_d;
            ack_q <= ack_d;
            rr_q  <= rr_d;
            vic_q <= vic_d;
        end
    end

    for (genvar e = 0; e < NAR; e++) begin : g_out
        assign resv_ch[4*e +: 4]   = ch_q[e];
        assign resv_adr[32*e +: 32] = adr_q[e];
    end
    assign resv_vld = vld_q;
    assign resv_ack = ack_q;
endmodule

// File: tb/tb_mpmc10_resv_mgr.sv
// tb_mpmc10_resv_mgr: directed scenarios with hand-computed expectations for
// the reservation manager (NCH=8, NAR=4, IDLE=0).
module tb_mpmc10_resv_mgr;
    localparam int NCH = 8;
    localparam int NAR = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        state = 4'd0;
    logic [NCH-1:0]    resv_req = '0;
    logic [32*NCH-1:0] resv_adr_i = '0;
    logic [NCH-1:0]    resv_ack;
    logic              wr = 1'b0;
    logic [3:0]        wch = 4'd0;
    logic [31:0]       wadr = '0;
    logic [4*NAR-1:0]  resv_ch;
    logic [32*NAR-1:0] resv_adr;
    logic [NAR-1:0]    resv_vld;

    int errors = 0;
    int checks = 0;
    logic [7:0] ak;

    mpmc10_resv_mgr #(.NCH(NCH), .NAR(NAR), .IDLE(4'd0)) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .resv_req(resv_req),
        .resv_adr_i(resv_adr_i), .resv_ack(resv_ack), .wr(wr), .wch(wch),
        .wadr(wadr), .resv_ch(resv_ch), .resv_adr(resv_adr), .resv_vld(resv_vld)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ch_of(int e);
        return resv_ch[4*e +: 4];
    endfunction

    function automatic logic [31:0] adr_of(int e);
        return resv_adr[32*e +: 32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        resv_req = '0;
        wr = 1'b0;
        state = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One request from a single channel, optionally with a write in the same cycle,
    // followed by an idle cycle so the same channel can be re-requested.
    task automatic reserve(input int ch, input logic [31:0] a, input logic w,
                           input logic [31:0] wa, output logic [7:0] ack_seen);
        resv_adr_i[32*ch +: 32] = a;
        resv_req[ch] = 1'b1;
        wr = w;
        wch = 4'(ch);
        wadr = wa;
        step();
        ack_seen = resv_ack;
        resv_req[ch] = 1'b0;
        wr = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++; if (resv_vld !== 4'b0) begin errors++; $display("FAIL reset_vld got %b exp 0000", resv_vld); end
        checks++; if (resv_ack !== 8'h0) begin errors++; $display("FAIL reset_ack got %h exp 00", resv_ack); end
        checks++; if (resv_ch !== 16'hFFFF) begin errors++; $display("FAIL reset_ch got %h exp ffff", resv_ch); end
        checks++; if (resv_adr !== '0) begin errors++; $display("FAIL reset_adr got %h exp 0", resv_adr); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        resv_adr_i[32*2 +: 32] = 32'h0000_1040;
        resv_req[2] = 1'b1;
        step();
        checks++; if (resv_ack !== 8'h04) begin errors++; $display("FAIL single_ack got %h exp 04", resv_ack); end
        checks++; if (ch_of(0) !== 4'd2) begin errors++; $display("FAIL single_ch got %h exp 2", ch_of(0)); end
        checks++; if (adr_of(0) !== 32'h1040) begin errors++; $display("FAIL single_adr got %h exp 1040", adr_of(0)); end
        checks++; if (resv_vld !== 4'b0001) begin errors++; $display("FAIL single_vld got %b exp 0001", resv_vld); end
        step();
        checks++; if (resv_ack !== 8'h00) begin errors++; $display("FAIL single_pulse got %h exp 00", resv_ack); end
        checks++; if (resv_vld !== 4'b0001) begin errors++; $display("FAIL single_noregrant_vld got %b exp 0001", resv_vld); end
        resv_req[2] = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        resv_adr_i[32*1 +: 32] = 32'h100;
        resv_adr_i[32*3 +: 32] = 32'h300;
        resv_adr_i[32*6 +: 32] = 32'h600;
        resv_req = 8'b0100_1010;
        step();
        checks++; if (resv_ack !== 8'h02) begin errors++; $display("FAIL rr_first got %h exp 02", resv_ack); end
        resv_req[1] = 1'b0;
        step();
        checks++; if (resv_ack !== 8'h08) begin errors++; $display("FAIL rr_second got %h exp 08", resv_ack); end
        resv_req[3] = 1'b0;
        step();
        checks++; if (resv_ack !== 8'h40) begin errors++; $display("FAIL rr_third got %h exp 40", resv_ack); end
        resv_req[6] = 1'b0;
        step();
        resv_req = 8'b0100_0010;
        step();
        checks++; if (resv_ack !== 8'h02) begin errors++; $display("FAIL rr_wrap got %h exp 02", resv_ack); end
        resv_req[1] = 1'b0;
        step();
        checks++; if (resv_ack !== 8'h40) begin errors++; $display("FAIL rr_wrap2 got %h exp 40", resv_ack); end
        resv_req[6] = 1'b0;
        step();
        checks++; if (resv_vld !== 4'b0111) begin errors++; $display("FAIL rr_vld got %b exp 0111", resv_vld); end
    endtask

    task automatic test_victim();
        do_reset();
        for (int i = 0; i < 4; i++) reserve(i, 32'h100 * (i + 1), 1'b0, 32'h0, ak);
        checks++; if (resv_vld !== 4'b1111) begin errors++; $display("FAIL victim_full got %b exp 1111", resv_vld); end
        reserve(4, 32'h2000, 1'b0, 32'h0, ak);
        checks++; if (ak !== 8'h10) begin errors++; $display("FAIL victim_ack4 got %h exp 10", ak); end
        checks++; if (ch_of(0) !== 4'd4 || adr_of(0) !== 32'h2000) begin errors++; $display("FAIL victim_e0 got %h/%h exp 4/2000", ch_of(0), adr_of(0)); end
        reserve(5, 32'h2400, 1'b0, 32'h0, ak);
        checks++; if (ch_of(1) !== 4'd5 || adr_of(1) !== 32'h2400) begin errors++; $display("FAIL victim_e1 got %h/%h exp 5/2400", ch_of(1), adr_of(1)); end
        checks++; if (ch_of(2) !== 4'd2 || resv_vld !== 4'b1111) begin errors++; $display("FAIL victim_keep got %h/%b exp 2/1111", ch_of(2), resv_vld); end
    endtask

    task automatic test_same_owner();
        do_reset();
        reserve(2, 32'h1040, 1'b0, 32'h0, ak);
        reserve(3, 32'h5000, 1'b0, 32'h0, ak);
        reserve(2, 32'h3000, 1'b0, 32'h0, ak);
        checks++; if (ak !== 8'h04) begin errors++; $display("FAIL owner_ack got %h exp 04", ak); end
        checks++; if (ch_of(0) !== 4'd2 || adr_of(0) !== 32'h3000) begin errors++; $display("FAIL owner_e0 got %h/%h exp 2/3000", ch_of(0), adr_of(0)); end
        checks++; if (resv_vld !== 4'b0011) begin errors++; $display("FAIL owner_vld got %b exp 0011", resv_vld); end
        checks++; if (ch_of(1) !== 4'd3) begin errors++; $display("FAIL owner_e1 got %h exp 3", ch_of(1)); end
    endtask

    task automatic test_clear();
        do_reset();
        reserve(1, 32'h1040, 1'b0, 32'h0, ak);
        reserve(3, 32'h105C, 1'b0, 32'h0, ak);
        reserve(4, 32'h1060, 1'b0, 32'h0, ak);
        wr = 1'b1; wch = 4'd1; wadr = 32'h1044;
        step();
        wr = 1'b0;
        checks++; if (resv_vld !== 4'b0100) begin errors++; $display("FAIL clear_vld got %b exp 0100", resv_vld); end
        checks++; if (ch_of(0) !== 4'hF || ch_of(1) !== 4'hF) begin errors++; $display("FAIL clear_ch got %h/%h exp f/f", ch_of(0), ch_of(1)); end
        checks++; if (ch_of(2) !== 4'd4) begin errors++; $display("FAIL clear_survive got %h exp 4", ch_of(2)); end
    endtask

    task automatic test_simultaneous();
        reserve(5, 32'h1070, 1'b1, 32'h1068, ak);
        checks++; if (resv_vld !== 4'b0001 || ch_of(0) !== 4'd5) begin errors++; $display("FAIL simul_new got %b/%h exp 0001/5", resv_vld, ch_of(0)); end
        checks++; if (ch_of(2) !== 4'hF) begin errors++; $display("FAIL simul_clr got %h exp f", ch_of(2)); end
        reserve(5, 32'h1078, 1'b1, 32'h1060, ak);
        checks++; if (resv_vld !== 4'b0001 || adr_of(0) !== 32'h1078) begin errors++; $display("FAIL simul_setwins got %b/%h exp 0001/1078", resv_vld, adr_of(0)); end
        reserve(6, 32'h8000, 1'b1, 32'h1070, ak);
        checks++; if (resv_vld !== 4'b0010 || ch_of(1) !== 4'd6 || adr_of(1) !== 32'h8000) begin errors++; $display("FAIL simul_diff got %b/%h/%h exp 0010/6/8000", resv_vld, ch_of(1), adr_of(1)); end
        checks++; if (ch_of(0) !== 4'hF) begin errors++; $display("FAIL simul_diff_clr got %h exp f", ch_of(0)); end
    endtask

    task automatic test_non_idle();
        do_reset();
        reserve(1, 32'h1040, 1'b0, 32'h0, ak);
        state = 4'd3;
        resv_adr_i[31:0] = 32'h7000;
        resv_req[0] = 1'b1;
        wr = 1'b1; wadr = 32'h1040;
        step();
        checks++; if (resv_ack !== 8'h00) begin errors++; $display("FAIL busy_ack got %h exp 00", resv_ack); end
        step();
        checks++; if (resv_vld !== 4'b0001 || ch_of(0) !== 4'd1) begin errors++; $display("FAIL busy_hold got %b/%h exp 0001/1", resv_vld, ch_of(0)); end
        state = 4'd0;
        wr = 1'b0;
        step();
        checks++; if (resv_ack !== 8'h01) begin errors++; $display("FAIL busy_release got %h exp 01", resv_ack); end
        checks++; if (ch_of(1) !== 4'd0 || adr_of(1) !== 32'h7000 || resv_vld !== 4'b0011) begin errors++; $display("FAIL busy_entry got %h/%h/%b exp 0/7000/0011", ch_of(1), adr_of(1), resv_vld); end
        resv_req[0] = 1'b0;
        resv_adr_i[32*2 +: 32] = 32'h9000;
        resv_req[2] = 1'b1;
        step();
        checks++; if (resv_ack !== 8'h04) begin errors++; $display("FAIL midreset_pre got %h exp 04", resv_ack); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (resv_ack !== 8'h00 || resv_vld !== 4'b0) begin errors++; $display("FAIL midreset got %h/%b exp 00/0000", resv_ack, resv_vld); end
        checks++; if (resv_ch !== 16'hFFFF || resv_adr !== '0) begin errors++; $display("FAIL midreset_tab got %h exp ffff", resv_ch); end
        resv_req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_victim();
        test_same_owner();
        test_clear();
        test_simultaneous();
        test_non_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mpmc10_resv_mgr.md
Name: mpmc10_resv_mgr

Overview:
Reservation table manager for the mpmc10 multi-port memory controller. Holds up to NAR load-reserved cache-line addresses, each tagged with its owning channel. Arbitrates reservation-set requests from NCH channels round-robin, and invalidates entries when a write commits to a reserved line. Drives the resv_ch/resv_adr arrays consumed by the per-channel reservation status bit logic.

Parameters:
NCH, 8, number of requesting channels (1..15; channel code 4'hF is reserved as "invalid")
NAR, 4, number of reservation table entries (power of two, 2..16)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
state  input  4  controller state; table updates only when state==mpmc10_pkg::IDLE
resv_req  input  NCH  per-channel reservation-set request, level, held until resv_ack
resv_adr_i  input  32 x NCH  per-channel reservation address
resv_ack  output  NCH  one-cycle grant acknowledge, registered
wr  input  1  write commit strobe (qualified by state==IDLE)
wch  input  4  channel performing the write
wadr  input  32  write address
resv_ch  output  4 x NAR  owning channel per entry, 4'hF when invalid
resv_adr  output  32 x NAR  reserved address per entry
resv_vld  output  NAR  entry valid flags

Behaviour:
- Reset (async, rst_n low): resv_ch[*]=4'hF, resv_adr[*]=0, resv_vld=0, resv_ack=0, rr pointer=0, victim pointer=0. Reset mid-grant drops the pending ack; the requester re-arbitrates after reset.
- Line compare uses address bits [31:5] only (32-byte line); bits [4:0] are stored but ignored for matching.
- Eligibility: channel i is eligible when resv_req[i]=1 and resv_ack[i]=0 (blocks a re-grant while the requester is seeing its ack).
- Arbitration: only when state==IDLE. Grant the first eligible channel searching upward from rr with wrap-around modulo NCH. At most one grant per cycle. On grant, rr <= (granted+1) mod NCH. No grant leaves rr unchanged.
- Entry selection for granted channel g, in priority order: (1) a valid entry already owned by g, which is overwritten; (2) the lowest-index invalid entry; (3) the entry at the victim pointer, after which victim <= (victim+1) mod NAR. Victim advances only in case (3).
- A channel owns at most one entry. Any other entry tagged g is invalidated in the same cycle.
- Write entry: resv_ch=g, resv_adr=resv_adr_i[g], resv_vld=1. Registered. The table update and resv_ack[g]=1 are both visible in the cycle after the grant, so latency is 1 cycle from an eligible request to ack. resv_ack is a single-cycle pulse.
- Clear: when wr=1 and state==IDLE, every valid entry whose resv_adr[31:5]==wadr[31:5] is invalidated (resv_vld=0, resv_ch=4'hF), regardless of owner (covers store-conditional by the owner and plain stores by others).
- Simultaneous set and clear to the same line in one cycle: the set wins for the entry being written; all other matching entries are cleared.
- Simultaneous set and clear to different lines: both apply.
- state != IDLE: no grants, no clears, table and pointers hold. Requests remain pending. A wr strobe outside IDLE is ignored.
- Invalid entries always read resv_ch=4'hF so they never match a valid wch.

Test Plan:
- Reset, then req ch2 adr 0x0000_1040 in IDLE -> next cycle resv_ack[2]=1 for one cycle, entry0 = {ch2, 0x1040, vld}. req held in the ack cycle is not re-granted.
- Reqs ch1, ch3, ch6 asserted together from rr=0 -> acks in order ch1, ch3, ch6 on consecutive cycles. A subsequent ch1+ch6 pair is served ch1 first (rr=7 wraps to 0).
- Fill 4 entries (ch0..ch3), then req ch4 adr 0x2000 -> entry0 replaced (victim 0->1); next ch5 replaces entry1.
- ch2 holds 0x1040, ch2 reserves 0x3000 -> same entry updated, no second entry; resv_vld popcount unchanged.
- Entries ch1@0x1040 and ch3@0x105C, wr wch=1 wadr=0x1044 -> both invalidated (same line), resv_ch=4'hF. Entry ch4@0x1060 survives.
- state=non-IDLE with req ch0 and wr matching an entry -> no ack, table unchanged. Returning to IDLE -> ack next cycle; rst_n pulsed low mid-sequence -> all outputs at reset values immediately.
